// File: rtl/bench_stim_sequencer_if.sv
// Purpose: harness-side signal bundle for the benchmark stimulus sequencer.
// Latency: none, wires only.
// Backpressure: none; start/abort are level requests sampled by the sequencer.
interface bench_stim_sequencer_if;
    logic        start;
    logic        abort;
    logic [5:0]  dut_out;
    logic [2:0]  dut_in;
    logic        dut_rst;
    logic        busy;
    logic        done;
    logic        sig_valid;
    logic [15:0] signature;
    logic [15:0] pat_cnt;

    modport slave (
        input  start, abort, dut_out,
        output dut_in, dut_rst, busy, done, sig_valid, signature, pat_cnt
    );

    modport master (
        output start, abort, dut_out,
        input  dut_in, dut_rst, busy, done, sig_valid, signature, pat_cnt
    );
endinterface

// File: rtl/bench_stim_sequencer.sv
// Purpose: resets a benchmark core, drives LFSR patterns into it and compacts its outputs into a MISR.
// Latency: RST_CYCLES + N_PATTERNS + DRAIN_CYCLES + 1 cycles from accepted start to done; signature one cycle later.
// Backpressure: none; start is ignored while busy, abort returns to IDLE from any active state.
module bench_stim_sequencer #(
    parameter int unsigned N_PATTERNS   = 1000,
    parameter int unsigned RST_CYCLES   = 2,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED    = 16'h0001
) (
    input  logic                    blif_clk_net,
    input  logic                    blif_reset_net,
    bench_stim_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [15:0] SEED       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
    localparam logic [15:0] RUN_LAST   = 16'(N_PATTERNS - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
    localparam bit          HAS_RUN    = (N_PATTERNS != 0);
    localparam bit          HAS_DRAIN  = (DRAIN_CYCLES != 0);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] misr_q, misr_d;
    logic [15:0] sig_q, sig_d;
    logic [15:0] pat_q, pat_d;
    logic [2:0]  dut_in_q, dut_in_d;
    logic        dut_rst_q, dut_rst_d;
    logic        sig_vld_q, sig_vld_d;

    function automatic logic [15:0] shift_fb(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        sig_d     = sig_q;
        pat_d     = pat_q;
        sig_vld_d = sig_vld_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (bus.start) begin
                    state_d   = S_RST;
                    lfsr_d    = SEED;
                    misr_d    = 16'd0;
                    pat_d     = 16'd0;
                    sig_vld_d = 1'b0;
                end
            end
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = HAS_RUN ? S_RUN : (HAS_DRAIN ? S_DRAIN : S_DONE);
                end
            end
            S_RUN: begin
                misr_d = shift_fb(misr_q) ^ {10'b0, bus.dut_out};
                pat_d  = (pat_q == 16'hFFFF) ? pat_q : pat_q + 16'd1;
                if (cnt_q == RUN_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = HAS_DRAIN ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                misr_d = shift_fb(misr_q) ^ {10'b0, bus.dut_out};
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d     = 16'd0;
                sig_d     = misr_q;
                sig_vld_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided, including the DONE publish.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            cnt_d     = 16'd0;
            pat_d     = pat_q;
            sig_d     = sig_q;
            sig_vld_d = 1'b0;
        end

        // Core pins are registered from the state being entered, so the first RUN cycle shows the seed.
        dut_rst_d = (state_d == S_IDLE) || (state_d == S_RST);
        dut_in_d  = 3'b000;
        if (state_d == S_RUN) begin
            dut_in_d = lfsr_q[2:0];
            lfsr_d   = shift_fb(lfsr_q);
        end
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            lfsr_q    <= SEED;
            misr_q    <= 16'd0;
            sig_q     <= 16'd0;
            pat_q     <= 16'd0;
            dut_in_q  <= 3'b000;
            dut_rst_q <= 1'b1;
            sig_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            misr_q    <= misr_d;
            sig_q     <= sig_d;
            pat_q     <= pat_d;
            dut_in_q  <= dut_in_d;
            dut_rst_q <= dut_rst_d;
            sig_vld_q <= sig_vld_d;
        end
    end

    assign bus.dut_in    = dut_in_q;
    assign bus.dut_rst   = dut_rst_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.sig_valid = sig_vld_q;
    assign bus.signature = sig_q;
    assign bus.pat_cnt   = pat_q;

endmodule

// File: tb/tb_bench_stim_sequencer.sv
// Bench for bench_stim_sequencer: four parameterisations run side by side against a timeline model.
module tb_bench_stim_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic        start_s [4];
    logic        abort_s [4];
    logic [5:0]  out_s   [4];
    logic [2:0]  o_in    [4];
    logic        o_rst   [4];
    logic        o_busy  [4];
    logic        o_done  [4];
    logic        o_sv    [4];
    logic [15:0] o_sig   [4];
    logic [15:0] o_pc    [4];

    // Model: cycles since accepted start (0 = idle) plus published values.
    int          tm    [4];
    logic [15:0] misrm [4];
    logic [15:0] sigm  [4];
    logic [15:0] pcm   [4];
    logic        svm   [4];

    function automatic int unsigned np_of(input int k);
        case (k)
            0: return 4;
            1: return 1;
            2: return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int unsigned rc_of(input int k);
        return (k == 3) ? 1 : 2;
    endfunction

    function automatic int unsigned dc_of(input int k);
        return (k == 3) ? 2 : 0;
    endfunction

    function automatic logic [15:0] seed_of(input int k);
        case (k)
            0: return 16'h0001;
            1: return 16'hACE1;
            2: return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_at(input logic [15:0] s, input int i);
        logic [15:0] q;
        q = (s == 16'h0000) ? 16'h0001 : s;
        for (int j = 0; j < i; j++) q = {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        return q;
    endfunction

    function automatic logic [15:0] mstep(input logic [15:0] m, input logic [5:0] o);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {10'b0, o};
    endfunction

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            bench_stim_sequencer_if bus ();
            bench_stim_sequencer #(
                .N_PATTERNS  (np_of(g)),
                .RST_CYCLES  (rc_of(g)),
                .DRAIN_CYCLES(dc_of(g)),
                .LFSR_SEED   (seed_of(g))
            ) u_dut (
                .blif_clk_net  (clk),
                .blif_reset_net(rst_n),
                .bus           (bus.slave)
            );
            assign bus.start   = start_s[g];
            assign bus.abort   = abort_s[g];
            assign bus.dut_out = out_s[g];
            assign o_in[g]     = bus.dut_in;
            assign o_rst[g]    = bus.dut_rst;
            assign o_busy[g]   = bus.busy;
            assign o_done[g]   = bus.done;
            assign o_sv[g]     = bus.sig_valid;
            assign o_sig[g]    = bus.signature;
            assign o_pc[g]     = bus.pat_cnt;
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            tm[k] = 0; misrm[k] = 16'h0; sigm[k] = 16'h0; pcm[k] = 16'h0; svm[k] = 1'b0;
        end
    endtask

    task automatic compare_one(input int k);
        int          r, n, d, t;
        logic [15:0] l;
        logic [2:0]  ein;
        r = int'(rc_of(k)); n = int'(np_of(k)); d = int'(dc_of(k)); t = tm[k];
        ein = 3'b000;
        if (t > r && t <= r + n) begin
            l   = lfsr_at(seed_of(k), t - r - 1);
            ein = l[2:0];
        end
        chk($sformatf("u%0d_dut_in", k),    32'(o_in[k]),   32'(ein));
        chk($sformatf("u%0d_dut_rst", k),   32'(o_rst[k]),  32'(t <= r));
        chk($sformatf("u%0d_busy", k),      32'(o_busy[k]), 32'(t != 0));
        chk($sformatf("u%0d_done", k),      32'(o_done[k]), 32'(t == r + n + d + 1));
        chk($sformatf("u%0d_sig_valid", k), 32'(o_sv[k]),   32'(svm[k]));
        chk($sformatf("u%0d_signature", k), 32'(o_sig[k]),  32'(sigm[k]));
        chk($sformatf("u%0d_pat_cnt", k),   32'(o_pc[k]),   32'(pcm[k]));
    endtask

    task automatic model_step(input int k);
        int r, n, d, t;
        r = int'(rc_of(k)); n = int'(np_of(k)); d = int'(dc_of(k)); t = tm[k];
        if (t == 0) begin
            if (start_s[k]) begin
                tm[k] = 1; misrm[k] = 16'h0; pcm[k] = 16'h0; svm[k] = 1'b0;
            end
        end else if (abort_s[k]) begin
            tm[k] = 0; svm[k] = 1'b0;
        end else begin
            if (t > r && t <= r + n) begin
                misrm[k] = mstep(misrm[k], out_s[k]);
                pcm[k]   = (pcm[k] == 16'hFFFF) ? pcm[k] : pcm[k] + 16'd1;
            end else if (t > r + n && t <= r + n + d) begin
                misrm[k] = mstep(misrm[k], out_s[k]);
            end
            if (t == r + n + d + 1) begin
                sigm[k] = misrm[k]; svm[k] = 1'b1; tm[k] = 0;
            end else begin
                tm[k] = t + 1;
            end
        end
    endtask

    // Compare every cycle on the falling edge, then advance the model with the inputs the DUT will see next.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            for (int k = 0; k < 4; k++) compare_one(k);
            if (rst_n) for (int k = 0; k < 4; k++) model_step(k);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input bit also_others);
        logic [2:0] seq [4];
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b000;
        out_s[0] = 6'h00;
        start_s[0] = 1'b1;
        if (also_others) begin
            start_s[1] = 1'b1; start_s[2] = 1'b1; start_s[3] = 1'b1;
        end
        tick();
        for (int k = 0; k < 4; k++) start_s[k] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("a_rst_phase_dut_rst", 32'(o_rst[0]), 32'd1);
            chk("a_rst_phase_busy", 32'(o_busy[0]), 32'd1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a_run%0d_dut_in", i), 32'(o_in[0]), 32'(seq[i]));
            chk($sformatf("a_run%0d_dut_rst", i), 32'(o_rst[0]), 32'd0);
            tick();
        end
        chk("a_done_pulse", 32'(o_done[0]), 32'd1);
        chk("a_done_sig_valid_not_yet", 32'(o_sv[0]), 32'd0);
        tick();
        chk("a_after_done", 32'(o_done[0]), 32'd0);
        chk("a_busy_low", 32'(o_busy[0]), 32'd0);
        chk("a_sig_valid", 32'(o_sv[0]), 32'd1);
        chk("a_signature", 32'(o_sig[0]), 32'h0000);
        chk("a_pat_cnt", 32'(o_pc[0]), 32'd4);
        chk("a_model_pat_cnt", 32'(pcm[0]), 32'd4);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start_s[k] = 1'b0; abort_s[k] = 1'b0; out_s[k] = 6'h00;
        end
        out_s[1] = 6'h01;
        out_s[3] = 6'h01;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dut_rst", 32'(o_rst[0]), 32'd1);
        chk("reset_signature", 32'(o_sig[0]), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();

        // All four variants started together; all finish within the 7 cycles of variant 0.
        run_a(1'b1);
        chk("b_signature", 32'(o_sig[1]), 32'h0001);
        chk("b_pat_cnt", 32'(o_pc[1]), 32'd1);
        chk("c_signature", 32'(o_sig[2]), 32'h0000);
        chk("c_pat_cnt", 32'(o_pc[2]), 32'd0);
        chk("c_sig_valid", 32'(o_sv[2]), 32'd1);
        chk("d_signature", 32'(o_sig[3]), 32'h001F);
        chk("d_model_signature", 32'(sigm[3]), 32'h001F);
        chk("d_pat_cnt", 32'(o_pc[3]), 32'd3);
        tick();

        // Abort on the third RUN cycle.
        out_s[0] = 6'h2A;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        repeat (4) tick();
        abort_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0;
        chk("abort_dut_rst", 32'(o_rst[0]), 32'd1);
        chk("abort_dut_in", 32'(o_in[0]), 32'd0);
        chk("abort_sig_valid", 32'(o_sv[0]), 32'd0);
        chk("abort_busy", 32'(o_busy[0]), 32'd0);
        chk("abort_pat_cnt", 32'(o_pc[0]), 32'd2);
        repeat (3) tick();

        // Start and abort together in IDLE, then abort during DONE.
        start_s[1] = 1'b1; abort_s[1] = 1'b1;
        tick();
        start_s[1] = 1'b0; abort_s[1] = 1'b0;
        chk("b_start_wins", 32'(o_busy[1]), 32'd1);
        repeat (3) tick();
        chk("b_done_pulse", 32'(o_done[1]), 32'd1);
        abort_s[1] = 1'b1;
        tick();
        abort_s[1] = 1'b0;
        chk("b_abort_in_done_sig_valid", 32'(o_sv[1]), 32'd0);
        chk("b_abort_in_done_busy", 32'(o_busy[1]), 32'd0);
        repeat (2) tick();

        // Asynchronous reset in the middle of RUN.
        out_s[0] = 6'h15;
        start_s[0] = 1'b1; start_s[3] = 1'b1;
        tick();
        start_s[0] = 1'b0; start_s[3] = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("areset_dut_rst", 32'(o_rst[0]), 32'd1);
        chk("areset_dut_in", 32'(o_in[0]), 32'd0);
        chk("areset_busy", 32'(o_busy[0]), 32'd0);
        chk("areset_pat_cnt", 32'(o_pc[0]), 32'd0);
        chk("areset_d_signature", 32'(o_sig[3]), 32'd0);
        chk("areset_d_sig_valid", 32'(o_sv[3]), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        run_a(1'b0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
